ahb2apb_bridge: RTL and testbench

AHB2APB_BRIDGE -- requirements
Module: ahb2apb_bridge

---
 rtl/ahb_apb_pkg.sv | 38 +++
 rtl/apb_psel_dec.sv | 21 ++
 rtl/ahb2apb_bridge.sv | 148 ++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-to-APB bridge: FSM states, HSIZE
// encodings, default sizing and the APB4 strobe helper.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WDATA  = 3'd1,
    SETUP  = 3'd2,
    ACCESS = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } state_e;

  localparam logic [3:0] HSIZE_BYTE = 4'd0;
  localparam logic [3:0] HSIZE_HALF = 4'd1;
  localparam logic [3:0] HSIZE_WORD = 4'd2;

  localparam int DEF_NUM_PSEL = 6;
  localparam int DEF_TIMEOUT  = 255;

  // Reads never assert strobes; unsupported sizes are rejected before use.
  function automatic logic [3:0] strb_calc(input logic [3:0] size,
                                           input logic [1:0] addr,
                                           input logic       write);
    logic [3:0] strb;
    strb = 4'h0;
    if (write) begin
      case (size)
        HSIZE_WORD: strb = 4'hF;
        HSIZE_HALF: strb = 4'h3 << {addr[1], 1'b0};
        HSIZE_BYTE: strb = 4'h1 << addr;
        default:    strb = 4'h0;
      endcase
    end
    return strb;
  endfunction

endpackage

// File: rtl/apb_psel_dec.sv
// Decodes the 4-bit peripheral index into a one-hot APB select and flags
// indices that have no peripheral behind them.
module apb_psel_dec
  import ahb_apb_pkg::*;
#(
  parameter int NUM_PSEL = DEF_NUM_PSEL
) (
  input  logic [3:0]          idx_i,
  output logic [NUM_PSEL-1:0] psel_o,
  output logic                invalid_o
);

  always_comb begin
    invalid_o = (32'(idx_i) >= NUM_PSEL);
    psel_o    = '0;
    for (int i = 0; i < NUM_PSEL; i++) begin
      if (!invalid_o && (32'(idx_i) == i)) psel_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge with address decode, write-data
// phase capture, pipelined back-to-back transfers and an ACCESS timeout.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int NUM_PSEL = DEF_NUM_PSEL,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                hsel,
  input  logic [31:0]         haddr,
  input  logic [3:0]          hsize,
  input  logic                hwrite,
  input  logic [31:0]         hwdata,
  output logic [31:0]         hrdata,
  output logic                hready,
  output logic                hresp,
  output logic [NUM_PSEL-1:0] psel,
  output logic                penable,
  output logic [15:0]         paddr,
  output logic                pwrite,
  output logic [31:0]         pwdata,
  output logic [3:0]          pstrb,
  input  logic [31:0]         prdata,
  input  logic                pready,
  input  logic                pslverr
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [NUM_PSEL-1:0] sel_q, sel_d;
  logic [NUM_PSEL-1:0] psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                hresp_q, hresp_d;
  logic [15:0]         paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_PSEL-1:0] dec_sel;
  logic                dec_bad;
  logic                xfer_ok;
  logic                cap;
  logic                bad_req;
  logic                unused_haddr;

  apb_psel_dec #(.NUM_PSEL(NUM_PSEL)) u_psel_dec (
    .idx_i    (haddr[19:16]),
    .psel_o   (dec_sel),
    .invalid_o(dec_bad)
  );

  assign unused_haddr = ^haddr[31:20];

  // hready must follow pready in the completion cycle, so it is decoded
  // from the registered state rather than registered itself.
  assign xfer_ok = (state_q == ACCESS) && pready && !pslverr;
  assign hready  = (state_q == IDLE) || (state_q == ERR2) || xfer_ok;
  assign cap     = hsel && hready;
  assign bad_req = dec_bad || (hsize > HSIZE_WORD);

  assign hrdata  = (xfer_ok && !pwrite_q) ? prdata : 32'h0;
  assign hresp   = hresp_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;
  assign pstrb   = pstrb_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      WDATA: begin
        pwdata_d = hwdata;
        state_d  = SETUP;
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d = pslverr ? ERR1 : IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO_MAX) state_d = ERR1;
        end
      end
      ERR1:    state_d = ERR2;
      ERR2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A capture overrides the default successor of IDLE, ERR2 and a good completion.
    if (cap) begin
      sel_d    = dec_sel;
      paddr_d  = haddr[15:0];
      pwrite_d = hwrite;
      pstrb_d  = strb_calc(hsize, haddr[1:0], hwrite);
      if (bad_req)     state_d = ERR1;
      else if (hwrite) state_d = WDATA;
      else             state_d = SETUP;
    end
  end

  assign psel_d    = ((state_d == SETUP) || (state_d == ACCESS)) ? sel_d : '0;
  assign penable_d = (state_d == ACCESS);
  assign hresp_d   = (state_d == ERR1) || (state_d == ERR2);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      hresp_q   <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      hresp_q   <= hresp_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed, table-driven bench for ahb2apb_bridge with hand-written sequences
// for timeout and reset-during-ACCESS.
module tb_ahb2apb_bridge;

  logic        hclk;
  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [3:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [5:0]  psel;
  logic        penable;
  logic [15:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int errors = 0;
  int checks = 0;

  ahb2apb_bridge #(.NUM_PSEL(6), .TIMEOUT(8)) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .hsel   (hsel),
    .haddr  (haddr),
    .hsize  (hsize),
    .hwrite (hwrite),
    .hwdata (hwdata),
    .hrdata (hrdata),
    .hready (hready),
    .hresp  (hresp),
    .psel   (psel),
    .penable(penable),
    .paddr  (paddr),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .prdata (prdata),
    .pready (pready),
    .pslverr(pslverr)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        hs;
    logic [31:0] ha;
    logic [3:0]  hz;
    logic        hw;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        pr;
    logic        pe;
    logic        e_hready;
    logic        e_hresp;
    logic [31:0] e_hrdata;
    logic [5:0]  e_psel;
    logic        e_penable;
    logic        chk_apb;
    logic [15:0] e_paddr;
    logic        e_pwrite;
    logic [31:0] e_pwdata;
    logic [3:0]  e_pstrb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(logic hs, logic [31:0] ha, logic [3:0] hz, logic hw,
                             logic [31:0] wd, logic [31:0] rd, logic pr, logic pe,
                             logic ery, logic ers, logic [31:0] erd, logic [5:0] eps,
                             logic een, logic ca, logic [15:0] epa, logic epw,
                             logic [31:0] epd, logic [3:0] est);
    vec_t r;
    r.hs = hs; r.ha = ha; r.hz = hz; r.hw = hw; r.wd = wd; r.rd = rd; r.pr = pr; r.pe = pe;
    r.e_hready = ery; r.e_hresp = ers; r.e_hrdata = erd; r.e_psel = eps; r.e_penable = een;
    r.chk_apb = ca; r.e_paddr = epa; r.e_pwrite = epw; r.e_pwdata = epd; r.e_pstrb = est;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_hready"},  0, 32'(hready),  32'h1);
    chk({tag, "_hresp"},   0, 32'(hresp),   32'h0);
    chk({tag, "_hrdata"},  0, hrdata,       32'h0);
    chk({tag, "_psel"},    0, 32'(psel),    32'h0);
    chk({tag, "_penable"}, 0, 32'(penable), 32'h0);
    chk({tag, "_paddr"},   0, 32'(paddr),   32'h0);
    chk({tag, "_pwrite"},  0, 32'(pwrite),  32'h0);
    chk({tag, "_pwdata"},  0, pwdata,       32'h0);
    chk({tag, "_pstrb"},   0, 32'(pstrb),   32'h0);
  endtask

  initial begin
    int n;
    hresetn = 1'b0; hsel = 1'b0; haddr = '0; hsize = '0; hwrite = 1'b0;
    hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;

    //           hs   haddr          hz    hw   hwdata         prdata         pr   pe     rdy  rsp  hrdata         psel   pen  chk  paddr     pwr  pwdata         pstrb
    // Word read 0x4002_0010, pready at first ACCESS
    vq.push_back(v(1'b1,32'h4002_0010,4'd2,1'b0,32'h0,        32'hA5A5_0001,1'b1,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0000,1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'hA5A5_0001,1'b1,1'b0, 1'b0,1'b0,32'h0,        6'h04,1'b0,1'b1,16'h0010,1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'hA5A5_0001,1'b1,1'b0, 1'b1,1'b0,32'hA5A5_0001,6'h04,1'b1,1'b1,16'h0010,1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'hA5A5_0001,1'b1,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0010,1'b0,32'h0,        4'h0));
    // Byte write 0x4003_0003, pready low 3 ACCESS cycles, ignored hsel while stalled
    vq.push_back(v(1'b1,32'h4003_0003,4'd0,1'b1,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0010,1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h1122_3344,32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0003,1'b1,32'h0,        4'h8));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h08,1'b0,1'b1,16'h0003,1'b1,32'h1122_3344,4'h8));
    vq.push_back(v(1'b1,32'h4005_0000,4'd2,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h08,1'b1,1'b1,16'h0003,1'b1,32'h1122_3344,4'h8));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h08,1'b1,1'b1,16'h0003,1'b1,32'h1122_3344,4'h8));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h08,1'b1,1'b1,16'h0003,1'b1,32'h1122_3344,4'h8));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'hFFFF_FFFF,1'b1,1'b0, 1'b1,1'b0,32'h0,        6'h08,1'b1,1'b1,16'h0003,1'b1,32'h1122_3344,4'h8));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0003,1'b1,32'h1122_3344,4'h8));
    // Read to invalid index 7
    vq.push_back(v(1'b1,32'h4007_0000,4'd2,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0003,1'b1,32'h1122_3344,4'h8));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b1,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b1,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    // Half-word write with pslverr, new read captured in ERR2
    vq.push_back(v(1'b1,32'h4001_0004,4'd1,1'b1,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'hCAFE_BABE,32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0004,1'b1,32'h1122_3344,4'h3));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h02,1'b0,1'b1,16'h0004,1'b1,32'hCAFE_BABE,4'h3));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b1,1'b1, 1'b0,1'b0,32'h0,        6'h02,1'b1,1'b1,16'h0004,1'b1,32'hCAFE_BABE,4'h3));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b1,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b1,32'h4000_0002,4'd1,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b1,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h01,1'b0,1'b1,16'h0002,1'b0,32'hCAFE_BABE,4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h1234_5678,1'b1,1'b0, 1'b1,1'b0,32'h1234_5678,6'h01,1'b1,1'b1,16'h0002,1'b0,32'hCAFE_BABE,4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h1234_5678,1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0002,1'b0,32'hCAFE_BABE,4'h0));
    // Back-to-back reads, second captured in the completion cycle
    vq.push_back(v(1'b1,32'h4004_0008,4'd2,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0002,1'b0,32'hCAFE_BABE,4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h10,1'b0,1'b1,16'h0008,1'b0,32'hCAFE_BABE,4'h0));
    vq.push_back(v(1'b1,32'h4005_000C,4'd2,1'b0,32'h0,        32'h0000_BEEF,1'b1,1'b0, 1'b1,1'b0,32'h0000_BEEF,6'h10,1'b1,1'b1,16'h0008,1'b0,32'hCAFE_BABE,4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h20,1'b0,1'b1,16'h000C,1'b0,32'hCAFE_BABE,4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0000_0055,1'b1,1'b0, 1'b1,1'b0,32'h0000_0055,6'h20,1'b1,1'b1,16'h000C,1'b0,32'hCAFE_BABE,4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    // Unsupported hsize=3, then upper half-word write (pstrb 4'hC)
    vq.push_back(v(1'b1,32'h4000_0000,4'd3,1'b1,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b1,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b1,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b1,32'h4002_0006,4'd1,1'b1,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b0,16'h0,    1'b0,32'h0,        4'h0));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h55AA_0000,32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0006,1'b1,32'hCAFE_BABE,4'hC));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b0,1'b0,32'h0,        6'h04,1'b0,1'b1,16'h0006,1'b1,32'h55AA_0000,4'hC));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0000_0077,1'b1,1'b0, 1'b1,1'b0,32'h0,        6'h04,1'b1,1'b1,16'h0006,1'b1,32'h55AA_0000,4'hC));
    vq.push_back(v(1'b0,32'h0,        4'd0,1'b0,32'h0,        32'h0,        1'b0,1'b0, 1'b1,1'b0,32'h0,        6'h00,1'b0,1'b1,16'h0006,1'b1,32'h55AA_0000,4'hC));

    #3;
    chk_rst("reset");
    repeat (2) @(posedge hclk);
    #2 hresetn = 1'b1;

    foreach (vq[i]) begin
      hsel = vq[i].hs; haddr = vq[i].ha; hsize = vq[i].hz; hwrite = vq[i].hw;
      hwdata = vq[i].wd; prdata = vq[i].rd; pready = vq[i].pr; pslverr = vq[i].pe;
      #1;
      chk("hready",  i, 32'(hready),  32'(vq[i].e_hready));
      chk("hresp",   i, 32'(hresp),   32'(vq[i].e_hresp));
      chk("hrdata",  i, hrdata,       vq[i].e_hrdata);
      chk("psel",    i, 32'(psel),    32'(vq[i].e_psel));
      chk("penable", i, 32'(penable), 32'(vq[i].e_penable));
      if (vq[i].chk_apb) begin
        chk("paddr",  i, 32'(paddr),  32'(vq[i].e_paddr));
        chk("pwrite", i, 32'(pwrite), 32'(vq[i].e_pwrite));
        chk("pwdata", i, pwdata,      vq[i].e_pwdata);
        chk("pstrb",  i, 32'(pstrb),  32'(vq[i].e_pstrb));
      end
      @(posedge hclk);
      #2;
    end

    // Timeout: pready stuck low on a read to index 1
    hsel = 1'b1; haddr = 32'h4001_0020; hsize = 4'd2; hwrite = 1'b0;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    @(posedge hclk); #2;
    hsel = 1'b0;
    #1;
    chk("to_setup_psel", 0, 32'(psel), 32'h02);
    n = 0;
    while (n < 20) begin
      @(posedge hclk); #3;
      if (penable === 1'b1 && psel === 6'h02 && hready === 1'b0) n++;
      else break;
    end
    chk("to_access_cycles", 0, 32'(n), 32'd8);
    chk("to_err1_psel",   0, 32'(psel),    32'h0);
    chk("to_err1_penable",0, 32'(penable), 32'h0);
    chk("to_err1_hready", 0, 32'(hready),  32'h0);
    chk("to_err1_hresp",  0, 32'(hresp),   32'h1);
    @(posedge hclk); #3;
    chk("to_err2_hready", 0, 32'(hready), 32'h1);
    chk("to_err2_hresp",  0, 32'(hresp),  32'h1);
    @(posedge hclk); #3;
    chk("to_idle_hresp",  0, 32'(hresp),  32'h0);

    // Reset asserted in the middle of an ACCESS cycle
    hsel = 1'b1; haddr = 32'h4000_0004; hsize = 4'd2; hwrite = 1'b0; pready = 1'b0;
    @(posedge hclk); #2;
    hsel = 1'b0;
    @(posedge hclk); #3;
    chk("rst_pre_penable", 0, 32'(penable), 32'h1);
    #2;
    hresetn = 1'b0; pready = 1'b1; prdata = 32'hDEAD_BEEF;
    #1;
    chk_rst("midrst");
    @(posedge hclk); #2;
    hresetn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("post_rst_hready", k, 32'(hready),  32'h1);
      chk("post_rst_hrdata", k, hrdata,       32'h0);
      chk("post_rst_psel",   k, 32'(psel),    32'h0);
      chk("post_rst_hresp",  k, 32'(hresp),   32'h0);
      @(posedge hclk); #2;
    end
    pready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
